// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the iterative RV32M multiply/divide unit.
//   - funct3 encodings F3_MUL..F3_REMU
//   - FSM state encoding
//   - latched-op struct carried through the iteration
//   - helpers: is_div, rs1_signed, rs2_signed
package muldiv_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Op context latched at accept; magnitudes live in the datapath.
    typedef struct packed {
        logic [2:0] funct3;
        logic       sign_a;
        logic       sign_b;
    } op_t;

    function automatic logic is_div(input logic [2:0] f3);
        return f3[2];
    endfunction

    function automatic logic rs1_signed(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    function automatic logic rs2_signed(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

endpackage

// File: rtl/muldiv_operand_prep.sv
// muldiv_operand_prep: combinational sign/magnitude split of both operands.
//   funct3        in   op select, decides which operands are treated as signed
//   rs1_val/rs2_val in operands
//   sign_a/sign_b out  operand is signed-interpreted and negative
//   abs_a/abs_b   out  magnitudes (0x8000_0000 stays 0x8000_0000, read as unsigned)
module muldiv_operand_prep
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    output logic            sign_a,
    output logic            sign_b,
    output logic [XLEN-1:0] abs_a,
    output logic [XLEN-1:0] abs_b
);

    always_comb begin
        sign_a = rs1_signed(funct3) & rs1_val[XLEN-1];
        sign_b = rs2_signed(funct3) & rs2_val[XLEN-1];
        abs_a  = sign_a ? (~rs1_val + 1'b1) : rs1_val;
        abs_b  = sign_b ? (~rs2_val + 1'b1) : rs2_val;
    end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M execute unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
// Radix-2 shift-add multiply and restoring divide on magnitudes, one step per cycle,
// sign fix-up applied when the last step retires.
//   clk, rst        clock, synchronous active-high reset
//   flush           abort op in progress / block acceptance
//   in_valid/in_ready, funct3, rs1_val, rs2_val   request side
//   out_valid/out_ready, result                   response side (result held in DONE)
//   busy            unit not idle (hazard stall)
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam int CNT_W = $clog2(XLEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

    state_t            state, state_nx;
    logic [CNT_W-1:0]  cnt;
    op_t               op;
    logic [XLEN-1:0]   md;      // |rs2|: multiplicand or divisor
    logic [2*XLEN-1:0] acc;     // mul: {partial hi, multiplier}; div: {remainder, quotient}

    logic              sign_a, sign_b;
    logic [XLEN-1:0]   abs_a, abs_b;

    muldiv_operand_prep #(.XLEN(XLEN)) u_prep (
        .funct3  (funct3),
        .rs1_val (rs1_val),
        .rs2_val (rs2_val),
        .sign_a  (sign_a),
        .sign_b  (sign_b),
        .abs_a   (abs_a),
        .abs_b   (abs_b)
    );

    // Accept-time shortcuts: divide by zero and signed overflow bypass iteration.
    logic            accept, div_zero, div_ovf, fast;
    logic [XLEN-1:0] fast_res;

    always_comb begin
        accept   = (state == ST_IDLE) && in_valid && !flush;
        div_zero = is_div(funct3) && (rs2_val == '0);
        div_ovf  = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
                   (rs1_val == {1'b1, {(XLEN-1){1'b0}}}) && (&rs2_val);
        fast     = div_zero || div_ovf;
        fast_res = '0;
        if (div_zero)
            fast_res = funct3[1] ? rs1_val : '1;
        else if (div_ovf)
            fast_res = funct3[1] ? '0 : rs1_val;
    end

    // One iteration step and the retired result it would produce.
    logic [XLEN:0]     mul_sum, div_trial;
    logic [2*XLEN-1:0] acc_nx, prod_fix;
    logic [XLEN-1:0]   quo, rem, calc_res;

    always_comb begin
        mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, md} : '0);
        // Shifted remainder is XLEN+1 bits; a negative trial means keep the shift.
        div_trial = acc[2*XLEN-1:XLEN-1] - {1'b0, md};
        if (is_div(op.funct3))
            acc_nx = div_trial[XLEN] ? {acc[2*XLEN-2:0], 1'b0}
                                     : {div_trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        else
            acc_nx = {mul_sum, acc[XLEN-1:1]};

        prod_fix = (op.sign_a ^ op.sign_b) ? (~acc_nx + 1'b1) : acc_nx;
        quo      = acc_nx[XLEN-1:0];
        rem      = acc_nx[2*XLEN-1:XLEN];

        calc_res = '0;
        case (op.funct3)
            F3_MUL:                       calc_res = prod_fix[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: calc_res = prod_fix[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:              calc_res = (op.sign_a ^ op.sign_b) ? (~quo + 1'b1) : quo;
            default:                      calc_res = op.sign_a ? (~rem + 1'b1) : rem;
        endcase
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (accept) state_nx = fast ? ST_DONE : ST_CALC;
            ST_CALC: if (flush) state_nx = ST_IDLE;
                     else if (cnt == CNT_LAST) state_nx = ST_DONE;
            ST_DONE: if (flush || out_ready) state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == ST_IDLE);
        out_valid = (state == ST_DONE);
        busy      = (state != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            op     <= '0;
            md     <= '0;
            acc    <= '0;
            result <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                op     <= '{funct3: funct3, sign_a: sign_a, sign_b: sign_b};
                md     <= abs_b;
                acc    <= {{XLEN{1'b0}}, abs_a};
                cnt    <= '0;
                if (fast)
                    result <= fast_res;
            end else if (state == ST_CALC) begin
                if (flush) begin
                    cnt <= '0;
                end else begin
                    acc <= acc_nx;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_LAST)
                        result <= calc_res;
                end
            end
        end
    end

endmodule
